// File: rtl/seq_converter_cgrundey_if.sv
// Operand/result handshake bundle for seq_converter_cgrundey.
// conv_par exists only when CONV_PARITY_EN is defined.
interface seq_converter_cgrundey_if #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
);
  logic [1:0]          conv_sel;
  logic [WIDTH-1:0]    conv_in;
  logic                in_valid;
  logic                in_ready;
  logic [4*DIGITS-1:0] conv_out;
  logic                out_valid;
  logic                out_ready;
`ifdef CONV_PARITY_EN
  logic                conv_par;

  modport master (
    output conv_sel, conv_in, in_valid, out_ready,
    input  in_ready, conv_out, out_valid, conv_par
  );
  modport slave (
    input  conv_sel, conv_in, in_valid, out_ready,
    output in_ready, conv_out, out_valid, conv_par
  );
`else
  modport master (
    output conv_sel, conv_in, in_valid, out_ready,
    input  in_ready, conv_out, out_valid
  );
  modport slave (
    input  conv_sel, conv_in, in_valid, out_ready,
    output in_ready, conv_out, out_valid
  );
`endif
endinterface

// File: rtl/seq_converter_cgrundey.sv
// Gray/binary/BCD code converter with valid/ready handshake.
// Optional registered even parity output under CONV_PARITY_EN.
module seq_converter_cgrundey #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input logic                    clk,
  input logic                    rst,
  seq_converter_cgrundey_if.slave bus
);

  localparam int BW = 4 * DIGITS;
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [WIDTH-1:0] op_q;
  logic [WIDTH-1:0] op_d;
  logic [BW-1:0]    bcd_q;
  logic [BW-1:0]    bcd_d;
  logic [BW-1:0]    adj;
  logic [CW-1:0]    cnt_q;
  logic [BW-1:0]    out_q;
  logic [WIDTH-1:0] gray;
  logic [WIDTH-1:0] bin;
  logic [BW-1:0]    simple_res;
  logic [BW-1:0]    load_val;
  logic             accept;
  logic             is_bcd;
  logic             last_it;
  logic             load;

  assign accept  = bus.in_valid && (state_q == IDLE);
  assign is_bcd  = (bus.conv_sel == 2'b10);
  assign last_it = (state_q == CALC) && (cnt_q == CW'(1));
  assign load    = (accept && !is_bcd) || last_it;

  // Single-cycle conversions of the live operand (captured on accept)
  always_comb begin
    gray = bus.conv_in ^ (bus.conv_in >> 1);
    bin  = '0;
    for (int i = 0; i < WIDTH; i++) begin
      bin[i] = ^(bus.conv_in >> i);
    end
    unique case (bus.conv_sel)
      2'b00:   simple_res = BW'(gray);
      2'b01:   simple_res = BW'(bin);
      default: simple_res = BW'(bus.conv_in);
    endcase
  end

  // One double-dabble step: add 3 to digits >= 5, then shift left
  always_comb begin
    adj = bcd_q;
    for (int d = 0; d < DIGITS; d++) begin
      if (bcd_q[4*d +: 4] >= 4'd5) begin
        adj[4*d +: 4] = bcd_q[4*d +: 4] + 4'd3;
      end
    end
    bcd_d    = {adj[BW-2:0], op_q[WIDTH-1]};
    op_d     = op_q << 1;
    load_val = accept ? simple_res : bcd_d;
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (accept) state_d = is_bcd ? CALC : DONE;
      CALC: if (last_it) state_d = DONE;
      DONE: if (bus.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Operand capture, BCD iteration and result register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q  <= '0;
      bcd_q <= '0;
      cnt_q <= '0;
      out_q <= '0;
    end else begin
      if (accept) begin
        op_q  <= bus.conv_in;
        bcd_q <= '0;
        cnt_q <= is_bcd ? CW'(WIDTH) : '0;
      end else if (state_q == CALC) begin
        op_q  <= op_d;
        bcd_q <= bcd_d;
        cnt_q <= cnt_q - CW'(1);
      end
      if (load) out_q <= load_val;
    end
  end

`ifdef CONV_PARITY_EN
  logic par_q;

  // Parity tracks the result register
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       par_q <= 1'b0;
    else if (load) par_q <= ^load_val;
  end

  assign bus.conv_par = par_q;
`endif

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.conv_out  = out_q;

endmodule

// File: doc/seq_converter_cgrundey.md
SEQ_CONVERTER_CGRUNDEY -- requirements
Module: seq_converter_cgrundey

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the input code width in bits (legal range 2..16).
REQ-002 The block SHALL have parameter DIGITS, default 3, giving the BCD digit count; legal only when 4*DIGITS >= WIDTH and 10^DIGITS > 2^WIDTH-1.
REQ-003 Port clk  input  1  single rising-edge clock.
REQ-004 Port rst  input  1  reset, asynchronous, active-high.
REQ-005 Port conv_sel  input  2  mode select: 00 bin->gray, 01 gray->bin, 10 bin->BCD, 11 passthrough.
REQ-006 Port conv_in  input  WIDTH  operand.
REQ-007 Port in_valid  input  1  operand and conv_sel valid.
REQ-008 Port in_ready  output  1  block can accept an operand.
REQ-009 Port conv_out  output  4*DIGITS  result; gray, binary and passthrough results zero-extended.
REQ-010 Port out_valid  output  1  conv_out holds a valid result.
REQ-011 Port out_ready  input  1  consumer accepts the result.
REQ-012 Port conv_par  output  1  even parity of conv_out; present only under CONV_PARITY_EN.

Function
REQ-013 FSM states SHALL be IDLE, CALC and DONE.
REQ-014 in_ready SHALL be 1 in IDLE only; out_valid SHALL be 1 in DONE only.
REQ-015 Accept SHALL occur on the rising edge where in_valid && in_ready; conv_in and conv_sel are captured there, and later changes on those inputs are ignored.
REQ-016 In modes 00, 01 and 11, accept SHALL move the FSM IDLE->DONE with the result registered, giving 1-cycle latency.
REQ-017 Mode 00 SHALL produce g = b ^ (b >> 1).
REQ-018 Mode 01 SHALL produce b[WIDTH-1] = g[WIDTH-1] and b[i] = b[i+1] ^ g[i].
REQ-019 Mode 11 SHALL return conv_in unchanged.
REQ-020 Mode 10 accept SHALL move IDLE->CALC, clear the BCD accumulator and load an iteration counter with WIDTH.
REQ-021 Each CALC cycle SHALL add 3 to every BCD digit >= 5, then shift {bcd, operand} left by 1 and decrement the counter.
REQ-022 The FSM SHALL leave CALC for DONE on the edge that completes the last iteration, so out_valid rises WIDTH+1 edges after accept.
REQ-023 In DONE, conv_out SHALL stay stable while out_ready = 0.
REQ-024 DONE SHALL return to IDLE on the edge with out_ready = 1.
REQ-025 Back-to-back operation SHALL have a minimum spacing of 2 cycles per operand in modes 00, 01 and 11; there is no result bypass.
REQ-026 in_valid asserted outside IDLE SHALL be ignored and SHALL NOT be queued.
REQ-027 conv_out SHALL retain the last result in IDLE and CALC; the internal accumulator is not visible until DONE.
REQ-028 WIDTH = 16 with DIGITS = 5 SHALL convert 65535 correctly in mode 10, with no overflow flag.

Reset
REQ-029 Asserting rst SHALL immediately force the FSM to IDLE, conv_out to 0, out_valid to 0, in_ready to 1 and the counter to 0, regardless of clock.
REQ-030 Reset mid-CALC or mid-DONE SHALL discard the operation, with no result emitted after release.
REQ-031 The first accept SHALL be possible on the first rising edge after rst deasserts.

Configuration
REQ-032 With macro CONV_PARITY_EN defined, port conv_par SHALL exist, be registered together with conv_out, equal ^conv_out, and be 0 on reset.
REQ-033 Without CONV_PARITY_EN, port conv_par and its logic SHALL be absent and all other behaviour SHALL be identical.

Verification
REQ-034 Mode 00, conv_in = 8'h19, in_valid pulse -> out_valid 1 cycle later, conv_out = 12'h015.
REQ-035 Mode 01, conv_in = 8'h0E -> conv_out = 12'h00B after 1 cycle; mode 11, conv_in = 8'h14 -> conv_out = 12'h014.
REQ-036 Mode 10, conv_in = 8'hFF -> in_ready low for 9 cycles, out_valid on the 9th edge after accept, conv_out = 12'h255; conv_in = 8'h00 -> 12'h000.
REQ-037 Mode 10 result with out_ready held low 5 cycles -> conv_out and out_valid stable; new in_valid ignored; IDLE on the edge out_ready = 1.
REQ-038 rst pulsed 4 cycles into mode 10 CALC -> conv_out = 0 and out_valid = 0 asynchronously, no out_valid afterwards; next op 8'h19 mode 00 -> 12'h015.
REQ-039 Under CONV_PARITY_EN, mode 10 with 8'hFF -> conv_par = 1 (12'h255 has five ones).
